// File: rtl/deck_ctrl.sv
// Purpose : 52-card deck holder with LFSR Fisher-Yates shuffle and zero-bubble card dealing.
// Latency : SHUFFLE -> INIT next cycle; 52 init cycles + >=51 swap cycles before RDY; CARD_USED advances next cycle.
// Backpres: RDY is the only handshake; CARD_USED while RDY=0 is ignored, SHUFFLE always restarts.
// Ports   : CLK/RST (sync, active high), SHUFFLE, CARD_USED in;
//           RDY, CARD[5:0], CVAL[3:0], REMAIN[5:0], EMPTY out.
module deck_ctrl #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SHUFFLE,
  input  logic       CARD_USED,
  output logic       RDY,
  output logic [5:0] CARD,
  output logic [3:0] CVAL,
  output logic [5:0] REMAIN,
  output logic       EMPTY
);

  typedef enum logic [2:0] {IDLE, INIT, SHUF, READY, OUT} state_t;

  state_t     state;
  logic [7:0] lfsr;
  logic       lfsr_fb;
  logic [5:0] deck [52];
  logic [5:0] k;       // init write index
  logic [5:0] i;       // shuffle boundary, counts down 51..1
  logic [5:0] p;       // deal pointer
  logic [5:0] j;       // random swap partner candidate
  logic [3:0] rank;

  // Taps 8,6,5,4; from a nonzero seed this never reaches zero.
  assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign j       = lfsr[5:0];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      lfsr  <= SEED;
      k     <= '0;
      i     <= '0;
      p     <= '0;
    end else begin
      lfsr <= {lfsr[6:0], lfsr_fb};
      if (SHUFFLE) begin
        // Restart from any state; a coincident CARD_USED is dropped.
        state <= INIT;
        k     <= '0;
      end else begin
        case (state)
          INIT: begin
            deck[k] <= k;
            if (k == 6'd51) begin
              i     <= 6'd51;
              state <= SHUF;
            end else begin
              k <= k + 6'd1;
            end
          end
          SHUF: begin
            // Out-of-range candidates are rejected and retried, which keeps
            // the draw uniform over 0..i without a modulo.
            if (j <= i) begin
              deck[i] <= deck[j];
              deck[j] <= deck[i];
              if (i == 6'd1) begin
                p     <= '0;
                state <= READY;
              end else begin
                i <= i - 6'd1;
              end
            end
          end
          READY: begin
            if (CARD_USED) begin
              if (p == 6'd51) begin
                p     <= '0;
                state <= OUT;
              end else begin
                p <= p + 6'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign RDY    = (state == READY);
  assign EMPTY  = (state == OUT);
  assign CARD   = RDY ? deck[p] : 6'd0;
  assign REMAIN = RDY ? (6'd52 - p) : 6'd0;
  assign rank   = 4'(CARD % 6'd13);

  always_comb begin
    CVAL = 4'd0;
    if (RDY) begin
      if (rank == 4'd0)
        CVAL = 4'd1;
      else if (rank <= 4'd9)
        CVAL = rank + 4'd1;
      else
        CVAL = 4'd10;
    end
  end

endmodule

// File: tb/tb_deck_ctrl.sv
module tb_deck_ctrl;

  localparam logic [7:0] SEED = 8'hA5;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       SHUFFLE = 1'b0;
  logic       CARD_USED = 1'b0;
  logic       RDY;
  logic [5:0] CARD;
  logic [3:0] CVAL;
  logic [5:0] REMAIN;
  logic       EMPTY;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_deck [52];
  int first_order [52];
  int last_order [52];

  deck_ctrl #(.SEED(SEED)) dut (
    .CLK(CLK), .RST(RST), .SHUFFLE(SHUFFLE), .CARD_USED(CARD_USED),
    .RDY(RDY), .CARD(CARD), .CVAL(CVAL), .REMAIN(REMAIN), .EMPTY(EMPTY)
  );

  always #5 CLK = ~CLK;

  // Edges since the last edge that sampled RST high.
  always @(posedge CLK) cyc <= RST ? 0 : cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic int cval_of(input int c);
    int r;
    r = c % 13;
    if (r == 0) return 1;
    if (r <= 9) return r + 1;
    return 10;
  endfunction

  // Reference Fisher-Yates: shuffle sampled at edge s (relative to reset),
  // first swap decision uses the LFSR advanced s+52 times from SEED.
  task automatic build_model(input int s, output int n);
    logic [7:0] l;
    int ii, jj, tmp;
    bit done;
    l = SEED;
    for (int c = 0; c < s + 52; c++) l = lfsr_next(l);
    for (int c = 0; c < 52; c++) exp_deck[c] = c;
    ii = 51; n = 0; done = 0;
    while (!done) begin
      n++;
      jj = int'(l[5:0]);
      if (jj <= ii) begin
        tmp = exp_deck[ii]; exp_deck[ii] = exp_deck[jj]; exp_deck[jj] = tmp;
        if (ii == 1) done = 1;
        else ii--;
      end
      l = lfsr_next(l);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  task automatic pulse_shuffle(output int s);
    SHUFFLE = 1'b1;
    @(posedge CLK);
    #1 SHUFFLE = 1'b0;
    s = cyc;
  endtask

  task automatic wait_rdy(input int s, input int n);
    int budget;
    budget = 3000;
    while (!RDY && budget > 0) begin
      @(posedge CLK); #1;
      budget--;
    end
    chk("rdy_timeout", int'(RDY), 1);
    chk("rdy_min_latency", int'(cyc >= s + 103), 1);
    chk("rdy_latency", cyc, s + 52 + n);
    chk("remain_full", int'(REMAIN), 52);
    chk("empty_in_ready", int'(EMPTY), 0);
  endtask

  // Deal all 52 with CARD_USED held high; ends in the empty state.
  task automatic deal_all();
    bit seen [52];
    for (int c = 0; c < 52; c++) seen[c] = 0;
    for (int c = 0; c < 52; c++) begin
      chk("deal_rdy", int'(RDY), 1);
      chk("deal_card", int'(CARD), exp_deck[c]);
      chk("deal_cval", int'(CVAL), cval_of(exp_deck[c]));
      chk("deal_remain", int'(REMAIN), 52 - c);
      if (CARD < 6'd52) begin
        chk("deal_distinct", int'(seen[CARD]), 0);
        seen[CARD] = 1;
      end
      last_order[c] = int'(CARD);
      CARD_USED = 1'b1;
      @(posedge CLK); #1;
    end
    CARD_USED = 1'b0;
    chk("out_empty", int'(EMPTY), 1);
    chk("out_rdy", int'(RDY), 0);
    chk("out_remain", int'(REMAIN), 0);
    chk("out_card", int'(CARD), 0);
    chk("out_cval", int'(CVAL), 0);
  endtask

  initial begin
    int s, n;

    // Reset, then idle with no stimulus.
    do_reset();
    for (int c = 0; c < 100; c++) begin
      @(posedge CLK); #1;
      chk("idle_rdy", int'(RDY), 0);
      chk("idle_empty", int'(EMPTY), 0);
      chk("idle_remain", int'(REMAIN), 0);
      chk("idle_card", int'(CARD), 0);
    end
    CARD_USED = 1'b1;
    @(posedge CLK); #1 CARD_USED = 1'b0;
    chk("idle_card_used_ignored", int'(RDY), 0);

    // Fixed-timing shuffle and full deal against the reference model.
    do_reset();
    repeat (3) @(posedge CLK);
    #1 pulse_shuffle(s);
    build_model(s, n);
    chk("init_rdy", int'(RDY), 0);
    wait_rdy(s, n);
    deal_all();
    for (int c = 0; c < 52; c++) first_order[c] = last_order[c];

    // Empty state holds; CARD_USED there is ignored.
    CARD_USED = 1'b1;
    repeat (3) @(posedge CLK);
    #1 CARD_USED = 1'b0;
    chk("out_hold_empty", int'(EMPTY), 1);
    chk("out_hold_remain", int'(REMAIN), 0);

    // Reshuffle from empty, deal to REMAIN=30, then SHUFFLE+CARD_USED together.
    pulse_shuffle(s);
    chk("reshuf_empty_drop", int'(EMPTY), 0);
    build_model(s, n);
    wait_rdy(s, n);
    CARD_USED = 1'b1;
    repeat (22) @(posedge CLK);
    #1 chk("remain_30", int'(REMAIN), 30);
    chk("card_23rd", int'(CARD), exp_deck[22]);
    SHUFFLE = 1'b1;
    @(posedge CLK);
    #1 SHUFFLE = 1'b0;
    CARD_USED = 1'b0;
    s = cyc;
    chk("restart_rdy", int'(RDY), 0);
    chk("restart_empty", int'(EMPTY), 0);
    chk("restart_card", int'(CARD), 0);
    chk("restart_cval", int'(CVAL), 0);
    build_model(s, n);
    repeat (70) @(posedge CLK);
    #1 CARD_USED = 1'b1;
    repeat (3) @(posedge CLK);
    #1 CARD_USED = 1'b0;
    chk("shuf_card_used_rdy", int'(RDY), 0);
    wait_rdy(s, n);
    deal_all();

    // Reset in the middle of a shuffle, then replay the first deal timing.
    do_reset();
    repeat (3) @(posedge CLK);
    #1 pulse_shuffle(s);
    repeat (80) @(posedge CLK);
    #1 chk("midshuf_not_rdy", int'(RDY), 0);
    RST = 1'b1;
    @(posedge CLK); #1;
    chk("midrst_rdy", int'(RDY), 0);
    chk("midrst_empty", int'(EMPTY), 0);
    chk("midrst_remain", int'(REMAIN), 0);
    chk("midrst_card", int'(CARD), 0);
    chk("midrst_cval", int'(CVAL), 0);
    @(posedge CLK);
    #1 RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1 pulse_shuffle(s);
    chk("replay_s", s, 4);
    build_model(s, n);
    wait_rdy(s, n);
    deal_all();
    for (int c = 0; c < 52; c++) chk("replay_order", last_order[c], first_order[c]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/deck_ctrl.md
DECK_CTRL -- requirements
Module: deck_ctrl

Interface
REQ-001 SHALL have port CLK, input, 1, system clock; all state updates on its rising edge.
REQ-002 SHALL have port RST, input, 1, synchronous active-high reset, sampled on the rising edge of CLK.
REQ-003 SHALL have port SHUFFLE, input, 1, single-cycle request to rebuild and shuffle the deck.
REQ-004 SHALL have port CARD_USED, input, 1, single-cycle pulse from the game FSM consuming the presented card.
REQ-005 SHALL have port RDY, output, 1, high when CARD/CVAL hold a valid undealt card.
REQ-006 SHALL have port CARD, output, 6, card index 0..51 (suit = CARD/13, rank = CARD mod 13).
REQ-007 SHALL have port CVAL, output, 4, blackjack value of CARD.
REQ-008 SHALL have port REMAIN, output, 6, undealt cards left, 0..52.
REQ-009 SHALL have port EMPTY, output, 1, high when all 52 cards are dealt and no shuffle is in progress.
REQ-010 SHALL have parameter SEED, default 8'hA5, LFSR reset value; must be nonzero.

Function
REQ-011 SHALL hold the deck in a 52-entry x 6-bit register array with one-cycle two-entry swap capability.
REQ-012 SHALL run an 8-bit Fibonacci LFSR (taps 8,6,5,4) that advances every cycle in every state; it SHALL never reach zero.
REQ-013 SHALL implement states IDLE, INIT, SHUF, READY, OUT (empty).
REQ-014 In IDLE: RDY=0, EMPTY=0, REMAIN=0; SHUFFLE moves to INIT.
REQ-015 In INIT: write deck[k]=k for k=0..51, one entry per cycle (52 cycles); then load i=51 and go to SHUF.
REQ-016 In SHUF: each cycle j=LFSR[5:0]; if j<=i, swap deck[i] and deck[j] and decrement i; if j>i, retry next cycle with i unchanged.
REQ-017 SHUF SHALL exit to READY in the cycle after the swap with i=1 completes; then set pointer p=0, REMAIN=52.
REQ-018 In READY: RDY=1, CARD=deck[p], REMAIN=52-p, all combinational from registered p.
REQ-019 CARD_USED with RDY=1: p increments next cycle; RDY stays 1 with the next card (zero-bubble).
REQ-020 CARD_USED on the 52nd card (p=51): next cycle go to OUT, RDY=0, EMPTY=1, REMAIN=0.
REQ-021 CARD_USED while RDY=0 SHALL be ignored (no pointer change, no error).
REQ-022 In OUT: hold EMPTY=1 until SHUFFLE, which goes to INIT.
REQ-023 SHUFFLE in any state (including INIT, SHUF, READY) SHALL restart INIT next cycle; RDY and EMPTY drop to 0 the next cycle.
REQ-024 SHUFFLE and CARD_USED in the same cycle: SHUFFLE wins; the card is not counted.
REQ-025 CVAL: rank 0 -> 1 (ace); ranks 1..9 -> rank+1; ranks 10..12 -> 10; CVAL=0 whenever RDY=0.
REQ-026 CARD SHALL read 0 whenever RDY=0.
REQ-027 Each shuffled deck SHALL be a permutation of 0..51 (no duplicates, no omissions).

Reset
REQ-028 RST SHALL force IDLE, p=0, i=0, LFSR=SEED, RDY=0, EMPTY=0, REMAIN=0, CARD=0, CVAL=0 on the next edge.
REQ-029 RST SHALL take priority over SHUFFLE and CARD_USED, including mid-INIT or mid-SHUF; deck contents need not be cleared.

Verification
REQ-030 RST for 2 cycles, no stimulus -> RDY=0, EMPTY=0, REMAIN=0, CARD=0 for 100 cycles.
REQ-031 SHUFFLE pulse after reset -> RDY rises no earlier than 52+51+1 cycles later, REMAIN=52, EMPTY=0.
REQ-032 After shuffle, pulse CARD_USED 52 times back-to-back -> 52 distinct CARD values covering 0..51, REMAIN 52 down to 1, then EMPTY=1, RDY=0, REMAIN=0.
REQ-033 Force deck order via unshuffled check of CVAL mapping: CARD=0 -> 1, 9 -> 10, 12 -> 10, 13 -> 1, 51 -> 10.
REQ-034 SHUFFLE at REMAIN=30 with simultaneous CARD_USED -> RDY=0 next cycle, later RDY=1 with REMAIN=52; CARD_USED during SHUF -> no effect.
REQ-035 RST asserted mid-SHUF -> IDLE next cycle with all outputs at reset values; same SEED and SHUFFLE timing reproduce identical deal order.
